// File: rtl/tx_packet_sequencer.sv
// tx_packet_sequencer
//   Read-side controller for the packet storage FIFO. Pulls one byte at a time
//   from storage, parses DA(6) SA(6) LEN(2) PAYLOAD(LEN) FCS(FCS_BYTES), and
//   presents each byte to the transmitter over a valid/ack handshake. An
//   inter-frame gap follows every frame (completed or aborted).
//   Optional build macro: SEQ_STATS_EN adds stat_frames / stat_errors counters.
module tx_packet_sequencer #(
  parameter int MAX_LEN    = 1500,
  parameter int FCS_BYTES  = 4,
  parameter int IFG_CYCLES = 96,
  parameter int STALL_MAX  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pkt_ready,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_r_data,
  output logic        fifo_r_en,
  output logic        fifo_flush,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ack,
  output logic        tx_sof,
  output logic        tx_eof,
  output logic        busy,
  output logic        err_len,
  output logic        err_underrun
`ifdef SEQ_STATS_EN
  ,
  output logic [15:0] stat_frames,
  output logic [15:0] stat_errors
`endif
);

  // FSM states
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;
  localparam logic [2:0] S_ABORT   = 3'd5;

  // Frame fields
  localparam logic [2:0] F_DA  = 3'd0;
  localparam logic [2:0] F_SA  = 3'd1;
  localparam logic [2:0] F_LEN = 3'd2;
  localparam logic [2:0] F_PAY = 3'd3;
  localparam logic [2:0] F_FCS = 3'd4;

  localparam logic [10:0] ADDR_LAST  = 11'd5;
  localparam logic [10:0] FCS_LAST   = 11'(FCS_BYTES - 1);
  localparam logic [7:0]  STALL_LAST = 8'(STALL_MAX - 1);
  localparam logic [6:0]  GAP_LAST   = 7'(IFG_CYCLES - 1);
  localparam logic [15:0] MAX_LEN_V  = 16'(MAX_LEN);

  // Saturating increments: counters stop at all-ones instead of wrapping.
  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : (v + 11'd1);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

  function automatic logic [6:0] sat_inc7(input logic [6:0] v);
    return (v == 7'h7F) ? v : (v + 7'd1);
  endfunction

  // LEN is illegal when zero or larger than the biggest supported payload.
  function automatic logic len_bad(input logic [15:0] l);
    return (l == 16'd0) || (l > MAX_LEN_V);
  endfunction

  logic [2:0]  state_q, state_d;
  logic [2:0]  field_q, field_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  stall_cnt_q, stall_cnt_d;
  logic [6:0]  gap_cnt_q, gap_cnt_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        tx_sof_q, tx_sof_d;
  logic        tx_eof_q, tx_eof_d;
  logic        busy_q, busy_d;
  logic        fifo_flush_q, fifo_flush_d;
  logic        err_len_q, err_len_d;
  logic        err_underrun_q, err_underrun_d;
  logic        frame_done_s;
  logic [15:0] len_full_s;

  // The read strobe must sit in the FETCH cycle itself so the data returned one
  // cycle later lands in LOAD; it is therefore decoded from the state register.
  assign fifo_r_en = (state_q == S_FETCH) && !fifo_empty;

  assign len_full_s = {len_q[15:8], tx_data_q};

  // Next-state, field tracking, counters and output staging.
  always_comb begin
    state_d        = state_q;
    field_d        = field_q;
    byte_cnt_d     = byte_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    len_d          = len_q;
    tx_data_d      = tx_data_q;
    tx_valid_d     = tx_valid_q;
    tx_sof_d       = tx_sof_q;
    tx_eof_d       = tx_eof_q;
    fifo_flush_d   = 1'b0;
    err_len_d      = 1'b0;
    err_underrun_d = 1'b0;
    frame_done_s   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pkt_ready) begin
          state_d     = S_FETCH;
          field_d     = F_DA;
          byte_cnt_d  = 11'd0;
          stall_cnt_d = 8'd0;
          gap_cnt_d   = 7'd0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_FETCH: begin
        if (!fifo_empty) begin
          state_d     = S_LOAD;
          stall_cnt_d = 8'd0;
        end else if (stall_cnt_q == STALL_LAST) begin
          // This empty cycle is the STALL_MAX-th in a row.
          err_underrun_d = 1'b1;
          state_d        = S_ABORT;
          stall_cnt_d    = 8'd0;
        end else begin
          stall_cnt_d = sat_inc8(stall_cnt_q);
        end
      end

      S_LOAD: begin
        tx_data_d   = fifo_r_data;
        tx_valid_d  = 1'b1;
        tx_sof_d    = (field_q == F_DA) && (byte_cnt_q == 11'd0);
        tx_eof_d    = (field_q == F_FCS) && (byte_cnt_q == FCS_LAST);
        state_d     = S_PRESENT;
        stall_cnt_d = 8'd0;
      end

      S_PRESENT: begin
        if (tx_ack) begin
          tx_valid_d  = 1'b0;
          tx_sof_d    = 1'b0;
          tx_eof_d    = 1'b0;
          state_d     = S_FETCH;
          stall_cnt_d = 8'd0;
          case (field_q)
            F_DA: begin
              if (byte_cnt_q == ADDR_LAST) begin
                field_d    = F_SA;
                byte_cnt_d = 11'd0;
              end else begin
                byte_cnt_d = sat_inc11(byte_cnt_q);
              end
            end
            F_SA: begin
              if (byte_cnt_q == ADDR_LAST) begin
                field_d    = F_LEN;
                byte_cnt_d = 11'd0;
              end else begin
                byte_cnt_d = sat_inc11(byte_cnt_q);
              end
            end
            F_LEN: begin
              if (byte_cnt_q == 11'd0) begin
                len_d[15:8] = tx_data_q;
                byte_cnt_d  = 11'd1;
              end else begin
                len_d      = len_full_s;
                byte_cnt_d = 11'd0;
                if (len_bad(len_full_s)) begin
                  err_len_d = 1'b1;
                  state_d   = S_ABORT;
                end else begin
                  field_d = F_PAY;
                end
              end
            end
            F_PAY: begin
              if ({5'd0, byte_cnt_q} == (len_q - 16'd1)) begin
                field_d    = F_FCS;
                byte_cnt_d = 11'd0;
              end else begin
                byte_cnt_d = sat_inc11(byte_cnt_q);
              end
            end
            F_FCS: begin
              if (byte_cnt_q == FCS_LAST) begin
                state_d      = S_GAP;
                gap_cnt_d    = 7'd0;
                byte_cnt_d   = 11'd0;
                frame_done_s = 1'b1;
              end else begin
                byte_cnt_d = sat_inc11(byte_cnt_q);
              end
            end
            default: begin
              state_d    = S_ABORT;
              byte_cnt_d = 11'd0;
            end
          endcase
        end else begin
          state_d = S_PRESENT;
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = S_IDLE;
          gap_cnt_d = 7'd0;
        end else begin
          gap_cnt_d = sat_inc7(gap_cnt_q);
        end
      end

      S_ABORT: begin
        // The partially sent frame simply ends without tx_eof.
        fifo_flush_d = 1'b1;
        state_d      = S_GAP;
        gap_cnt_d    = 7'd0;
        byte_cnt_d   = 11'd0;
      end

      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
        tx_sof_d   = 1'b0;
        tx_eof_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset returns everything to idle with no flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      field_q        <= F_DA;
      byte_cnt_q     <= 11'd0;
      stall_cnt_q    <= 8'd0;
      gap_cnt_q      <= 7'd0;
      len_q          <= 16'd0;
      tx_data_q      <= 8'd0;
      tx_valid_q     <= 1'b0;
      tx_sof_q       <= 1'b0;
      tx_eof_q       <= 1'b0;
      busy_q         <= 1'b0;
      fifo_flush_q   <= 1'b0;
      err_len_q      <= 1'b0;
      err_underrun_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      field_q        <= field_d;
      byte_cnt_q     <= byte_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      len_q          <= len_d;
      tx_data_q      <= tx_data_d;
      tx_valid_q     <= tx_valid_d;
      tx_sof_q       <= tx_sof_d;
      tx_eof_q       <= tx_eof_d;
      busy_q         <= busy_d;
      fifo_flush_q   <= fifo_flush_d;
      err_len_q      <= err_len_d;
      err_underrun_q <= err_underrun_d;
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign tx_sof       = tx_sof_q;
  assign tx_eof       = tx_eof_q;
  assign busy         = busy_q;
  assign fifo_flush   = fifo_flush_q;
  assign err_len      = err_len_q;
  assign err_underrun = err_underrun_q;

`ifdef SEQ_STATS_EN
  logic [15:0] stat_frames_q, stat_frames_d;
  logic [15:0] stat_errors_q, stat_errors_d;

  // Frame and error tallies, updated alongside the events they count; both wrap.
  always_comb begin
    if (frame_done_s) begin
      stat_frames_d = stat_frames_q + 16'd1;
    end else begin
      stat_frames_d = stat_frames_q;
    end
    if (err_len_d || err_underrun_d) begin
      stat_errors_d = stat_errors_q + 16'd1;
    end else begin
      stat_errors_d = stat_errors_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_frames_q <= 16'd0;
      stat_errors_q <= 16'd0;
    end else begin
      stat_frames_q <= stat_frames_d;
      stat_errors_q <= stat_errors_d;
    end
  end

  assign stat_frames = stat_frames_q;
  assign stat_errors = stat_errors_q;
`endif

endmodule

// File: tb/tb_tx_packet_sequencer.sv
// Self-checking bench for tx_packet_sequencer: table of frame scenarios plus
// hand-written reset and back-to-back sequences.
`timescale 1ns/1ps
module tb_tx_packet_sequencer;

  localparam int MAX_LEN    = 1500;
  localparam int FCS_BYTES  = 4;
  localparam int IFG_CYCLES = 96;
  localparam int STALL_MAX  = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic       pkt_ready;
  logic       fifo_empty;
  logic [7:0] fifo_r_data;
  logic       fifo_r_en;
  logic       fifo_flush;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ack;
  logic       tx_sof;
  logic       tx_eof;
  logic       busy;
  logic       err_len;
  logic       err_underrun;
`ifdef SEQ_STATS_EN
  logic [15:0] stat_frames;
  logic [15:0] stat_errors;
`endif

  tx_packet_sequencer #(
    .MAX_LEN(MAX_LEN), .FCS_BYTES(FCS_BYTES),
    .IFG_CYCLES(IFG_CYCLES), .STALL_MAX(STALL_MAX)
  ) dut (
    .clk(clk), .rst(rst), .pkt_ready(pkt_ready), .fifo_empty(fifo_empty),
    .fifo_r_data(fifo_r_data), .fifo_r_en(fifo_r_en), .fifo_flush(fifo_flush),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ack(tx_ack), .tx_sof(tx_sof),
    .tx_eof(tx_eof), .busy(busy), .err_len(err_len), .err_underrun(err_underrun)
`ifdef SEQ_STATS_EN
    , .stat_frames(stat_frames), .stat_errors(stat_errors)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    len;
    int    ack_period;   // 1: ack always, N: ack when cycle%N==0
    int    avail;        // bytes present in storage, 0 = whole frame
    int    exp_err_len;
    int    exp_und;
    int    exp_bytes;
    int    exp_eof;
    int    exp_err_delay; // cycles from last ack to error pulse
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [0:4095];
  int mem_len, rd_ptr;
  int cyc = 0;
  int ack_period;
  int frames_target;

  logic [7:0] rx_data [0:4095];
  logic       rx_sof  [0:4095];
  logic       rx_eof  [0:4095];
  int rx_n, eof_n, sof_n, last_ack_cyc, err_len_n, und_n, flush_n;
  int err_cyc, flush_cyc, busy_low_cyc;
  int eof_cyc [0:1];
  int sof_cyc [0:1];
  logic       hold_prev;
  logic [7:0] prev_data;
  logic [2:0] prev_flags;
  int exp_stat_frames = 0;
  int exp_stat_errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] fbyte(input int base, input int i, input int len);
    logic [15:0] l;
    l = 16'(len);
    if (i == 12) return l[15:8];
    else if (i == 13) return l[7:0];
    else return 8'((i * 13 + base * 29 + 5) & 255);
  endfunction

  task automatic load_frame(input int base, input int len, input int off, output int total);
    int legal;
    legal = (len >= 1 && len <= MAX_LEN) ? 1 : 0;
    total = legal ? (14 + len + FCS_BYTES) : 20;
    for (int i = 0; i < total; i++) mem[off + i] = fbyte(base, i, len);
  endtask

  task automatic clear_obs();
    rx_n = 0; eof_n = 0; sof_n = 0; last_ack_cyc = -1;
    err_len_n = 0; und_n = 0; flush_n = 0;
    err_cyc = -1; flush_cyc = -1; busy_low_cyc = -1;
    eof_cyc[0] = -1; eof_cyc[1] = -1; sof_cyc[0] = -1; sof_cyc[1] = -1;
    hold_prev = 1'b0;
    rd_ptr = 0;
  endtask

  // One clock: drive ack, observe outputs at negedge, then model the FIFO read.
  task automatic step();
    logic rd;
    @(negedge clk);
    if (ack_period == 0) tx_ack = 1'b0;
    else if (ack_period == 1) tx_ack = 1'b1;
    else tx_ack = ((cyc % ack_period) == 0);
    if (hold_prev) begin
      chk("hold_data", int'(tx_data), int'(prev_data));
      chk("hold_flags", int'({tx_valid, tx_sof, tx_eof}), int'(prev_flags));
    end
    hold_prev  = tx_valid && !tx_ack;
    prev_data  = tx_data;
    prev_flags = {tx_valid, tx_sof, tx_eof};
    if (tx_valid && tx_ack) begin
      if (rx_n < 4096) begin
        rx_data[rx_n] = tx_data; rx_sof[rx_n] = tx_sof; rx_eof[rx_n] = tx_eof;
      end
      rx_n++;
      last_ack_cyc = cyc;
      if (tx_eof) begin eof_cyc[(eof_n < 2) ? eof_n : 1] = cyc; eof_n++; end
      if (tx_sof) begin sof_cyc[(sof_n < 2) ? sof_n : 1] = cyc; sof_n++; end
    end
    if (err_len) begin err_len_n++; err_cyc = cyc; end
    if (err_underrun) begin und_n++; err_cyc = cyc; end
    if (fifo_flush) begin flush_n++; flush_cyc = cyc; end
    if (!busy && busy_low_cyc < 0 && (eof_n >= frames_target || (err_len_n + und_n) > 0))
      busy_low_cyc = cyc;
    rd = fifo_r_en;
    @(posedge clk);
    #1;
    if (rd) begin fifo_r_data = mem[rd_ptr]; rd_ptr++; end
    fifo_empty = (rd_ptr >= mem_len);
    cyc++;
  endtask

  task automatic check_stats();
`ifdef SEQ_STATS_EN
    chk("stat_frames", int'(stat_frames), exp_stat_frames);
    chk("stat_errors", int'(stat_errors), exp_stat_errors);
`endif
  endtask

  task automatic run_vec(input vec_t v);
    int total, bad_data, bad_sof, bad_eof, is_err;
    clear_obs();
    load_frame(3, v.len, 0, total);
    mem_len = (v.avail > 0) ? v.avail : total;
    fifo_empty = (mem_len == 0);
    ack_period = v.ack_period;
    frames_target = 1;
    pkt_ready = 1'b1;
    for (int k = 0; k < 20000 && busy_low_cyc < 0; k++) begin
      step();
      if (busy) pkt_ready = 1'b0;
    end
    chk({v.name, " finished"}, int'(busy_low_cyc >= 0), 1);
    chk({v.name, " byte_count"}, rx_n, v.exp_bytes);
    bad_data = 0; bad_sof = 0; bad_eof = 0;
    for (int i = 0; i < rx_n && i < 4096; i++) begin
      if (rx_data[i] !== mem[i]) bad_data++;
      if (rx_sof[i] !== (i == 0)) bad_sof++;
      if (rx_eof[i] !== (v.exp_eof != 0 && i == v.exp_bytes - 1)) bad_eof++;
    end
    chk({v.name, " data_errors"}, bad_data, 0);
    chk({v.name, " sof_errors"}, bad_sof, 0);
    chk({v.name, " eof_errors"}, bad_eof, 0);
    chk({v.name, " err_len_pulses"}, err_len_n, v.exp_err_len);
    chk({v.name, " underrun_pulses"}, und_n, v.exp_und);
    is_err = v.exp_err_len + v.exp_und;
    chk({v.name, " flush_pulses"}, flush_n, is_err);
    if (is_err != 0) begin
      chk({v.name, " err_delay"}, err_cyc - last_ack_cyc, v.exp_err_delay);
      chk({v.name, " flush_delay"}, flush_cyc - err_cyc, 1);
      chk({v.name, " gap_after_abort"}, busy_low_cyc - flush_cyc, IFG_CYCLES);
    end else begin
      chk({v.name, " gap_after_eof"}, busy_low_cyc - eof_cyc[0], IFG_CYCLES + 1);
    end
    exp_stat_frames += v.exp_eof;
    exp_stat_errors += is_err;
    check_stats();
  endtask

  vec_t vecs [8];

  initial begin
    int total_a, total_b, diff;
    vecs[0] = '{"len4_ack1",     4,    1, 0,  0, 0, 22,   1, 0};
    vecs[1] = '{"len4_ack5",     4,    5, 0,  0, 0, 22,   1, 0};
    vecs[2] = '{"len1_min",      1,    1, 0,  0, 0, 19,   1, 0};
    vecs[3] = '{"len1501_bad",   1501, 1, 0,  1, 0, 14,   0, 1};
    vecs[4] = '{"len0_bad",      0,    1, 0,  1, 0, 14,   0, 1};
    vecs[5] = '{"len1500_max",   1500, 2, 0,  0, 0, 1518, 1, 0};
    vecs[6] = '{"underrun_b20",  4,    1, 20, 0, 1, 20,   0, STALL_MAX + 1};
    vecs[7] = '{"len256_ack3",   256,  3, 0,  0, 0, 274,  1, 0};

    rst = 1'b1; pkt_ready = 1'b0; fifo_empty = 1'b1; fifo_r_data = 8'd0;
    tx_ack = 1'b0; ack_period = 1; frames_target = 1; mem_len = 0;
    clear_obs();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", int'({fifo_r_en, fifo_flush, tx_data, tx_valid, tx_sof,
                               tx_eof, busy, err_len, err_underrun}), 0);
    @(negedge clk);
    rst = 1'b0;

    // Reset while a byte is being presented without ack.
    load_frame(1, 4, 0, total_a);
    mem_len = total_a;
    fifo_empty = 1'b0;
    ack_period = 0;
    pkt_ready = 1'b1;
    for (int k = 0; k < 50 && !tx_valid; k++) begin
      step();
      if (busy) pkt_ready = 1'b0;
    end
    chk("present_valid", int'(tx_valid), 1);
    chk("present_first_byte", int'(tx_data), int'(mem[0]));
    chk("present_sof", int'(tx_sof), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midframe_reset_outputs", int'({fifo_r_en, fifo_flush, tx_data, tx_valid, tx_sof,
                                        tx_eof, busy, err_len, err_underrun}), 0);
    @(negedge clk);
    rst = 1'b0;
    clear_obs();
    mem_len = 0;
    fifo_empty = 1'b1;
    ack_period = 1;
    repeat (4) step();
    chk("post_reset_busy", int'(busy), 0);
    chk("post_reset_flush_pulses", flush_n, 0);
    exp_stat_frames = 0;
    exp_stat_errors = 0;
    check_stats();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Two stored frames with pkt_ready held: the second must wait out the gap.
    clear_obs();
    load_frame(1, 4, 0, total_a);
    load_frame(2, 4, total_a, total_b);
    mem_len = total_a + total_b;
    fifo_empty = 1'b0;
    ack_period = 1;
    frames_target = 2;
    pkt_ready = 1'b1;
    for (int k = 0; k < 20000 && busy_low_cyc < 0; k++) begin
      step();
      if (eof_n >= 2) pkt_ready = 1'b0;
    end
    chk("b2b finished", int'(busy_low_cyc >= 0), 1);
    chk("b2b byte_count", rx_n, total_a + total_b);
    total_b = 0;
    for (int i = 0; i < rx_n && i < 4096; i++) if (rx_data[i] !== mem[i]) total_b++;
    chk("b2b data_errors", total_b, 0);
    chk("b2b sof_count", sof_n, 2);
    chk("b2b eof_count", eof_n, 2);
    diff = sof_cyc[1] - eof_cyc[0];
    chk("b2b gap_min", int'(diff >= IFG_CYCLES + 1), 1);
    // Gap, one IDLE cycle, then FETCH/LOAD/PRESENT of the first DA byte.
    chk("b2b sof_spacing", diff, IFG_CYCLES + 4);
    exp_stat_frames += 2;
    check_stats();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
